// File: rtl/mult_share_pkg.sv
// Shared constants and the round-robin pick helper for the time-shared multiplier arbiter.
package mult_share_pkg;

    localparam int MS_WIDTH    = 8;
    localparam int MS_PIPE     = 2;
    localparam int MS_MAX_REQ  = 8;
    localparam int MS_MAX_ID_W = 3;

    typedef logic [MS_MAX_REQ-1:0]  ms_vec_t;
    typedef logic [MS_MAX_ID_W-1:0] ms_idx_t;

    typedef struct packed {
        logic    found;
        ms_idx_t idx;
    } ms_pick_t;

    // First asserted requester at or after ptr, wrapping modulo n_req.
    function automatic ms_pick_t ms_rr_pick(
        input ms_vec_t     valid,
        input ms_idx_t     ptr,
        input int unsigned n_req
    );
        ms_pick_t    pick;
        int unsigned k;
        pick = '0;
        for (int unsigned off = 0; off < MS_MAX_REQ; off++) begin
            k = (32'(ptr) + off) % n_req;
            if (off < n_req && !pick.found && valid[ms_idx_t'(k)]) begin
                pick.found = 1'b1;
                pick.idx   = ms_idx_t'(k);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_share_pipe.sv
// Signed PIPE-stage multiplier carrying a valid bit and requester ID alongside each stage.
module mult_share_pipe
#(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2,
    parameter int ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [ID_W-1:0]           in_id,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    output logic [ID_W-1:0]           out_id,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] prod;
    logic [PIPE-1:0]           vld_d, vld_q;
    logic [ID_W-1:0]           id_d [PIPE];
    logic [ID_W-1:0]           id_q [PIPE];
    logic signed [2*WIDTH-1:0] p_d  [PIPE];
    logic signed [2*WIDTH-1:0] p_q  [PIPE];

    // Sign-extend before multiplying so the full 2*WIDTH product is kept.
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    always_comb begin
        // NOTE: every comb output gets a hold default first, so no path can infer a latch.
        vld_d = vld_q;
        id_d  = id_q;
        p_d   = p_q;
        if (en) begin
            vld_d[0] = in_valid;
            id_d[0]  = in_id;
            p_d[0]   = prod;
            for (int s = 1; s < PIPE; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
                p_d[s]   = p_q[s-1];
            end
        end
    end

    // NOTE: only valids and the visible output stage are reset; inner data is qualified by its valid.
    always_ff @(posedge clk) begin
        for (int s = 0; s < PIPE-1; s++) begin
            id_q[s] <= id_d[s];
            p_q[s]  <= p_d[s];
        end
        if (!rst_n) begin
            vld_q        <= '0;
            id_q[PIPE-1] <= '0;
            p_q[PIPE-1]  <= '0;
        end else begin
            vld_q        <= vld_d;
            id_q[PIPE-1] <= id_d[PIPE-1];
            p_q[PIPE-1]  <= p_d[PIPE-1];
        end
    end

    assign out_valid = vld_q[PIPE-1];
    assign out_id    = id_q[PIPE-1];
    assign p         = p_q[PIPE-1];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter time-sharing one pipelined signed multiplier among N_REQ requesters.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = MS_WIDTH,
    parameter  int PIPE  = MS_PIPE,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic [ID_W-1:0]          rsp_id
);

    logic [ID_W-1:0]         ptr_d, ptr_q;
    logic [ID_W-1:0]         grant;
    logic                    adv, issue;
    logic signed [WIDTH-1:0] op_a, op_b;
    ms_pick_t                pick;

    // A held response freezes every stage, so nothing may enter behind it.
    assign adv = !(rsp_valid && !rsp_ready);

    always_comb begin
        pick      = ms_rr_pick(ms_vec_t'(req_valid), ms_idx_t'(ptr_q), N_REQ);
        grant     = ID_W'(pick.idx);
        issue     = rst_n && adv && pick.found;
        req_ready = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
        op_a  = req_a[grant*WIDTH +: WIDTH];
        op_b  = req_b[grant*WIDTH +: WIDTH];
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (int'(grant) == N_REQ-1) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    mult_share_pipe #(
        .WIDTH (WIDTH),
        .PIPE  (PIPE),
        .ID_W  (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .in_valid  (issue),
        .in_id     (grant),
        .a         (op_a),
        .b         (op_b),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .p         (rsp_p)
    );

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench: exhaustive 2-bit products, round-robin, backpressure, wrap, reset and random soak.
module tb_mult_share_arb;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int PIPE  = 2;
    localparam int ID_W  = 2;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [N_REQ-1:0]       req_valid, req_ready;
    logic [N_REQ*WIDTH-1:0] req_a, req_b;
    logic                   rsp_valid, rsp_ready;
    logic [2*WIDTH-1:0]     rsp_p;
    logic [ID_W-1:0]        rsp_id;

    logic [1:0]      s_valid, s_ready;
    logic [2*SW-1:0] s_a, s_b;
    logic            s_rsp_valid, s_rsp_ready;
    logic [2*SW-1:0] s_rsp_p;
    logic [0:0]      s_rsp_id;

    always #5 clk = ~clk;

    mult_share_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH), .PIPE(PIPE)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    mult_share_arb #(.N_REQ(2), .WIDTH(SW), .PIPE(2)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (s_valid),
        .req_ready (s_ready),
        .req_a     (s_a),
        .req_b     (s_b),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (s_rsp_ready),
        .rsp_p     (s_rsp_p),
        .rsp_id    (s_rsp_id)
    );

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [2*WIDTH-1:0] p;
    } exp_t;

    typedef struct {
        logic signed [SW-1:0]   a;
        logic signed [SW-1:0]   b;
        logic signed [2*SW-1:0] p;
    } mul_vec_t;

    typedef struct {
        logic [N_REQ-1:0] valid;
        logic [N_REQ-1:0] ready;
    } rr_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t               sb[$];
    int                 wait_cnt[N_REQ];
    logic               prev_stall = 1'b0;
    logic [2*WIDTH-1:0] prev_p;
    logic [ID_W-1:0]    prev_id;

    logic signed [63:0] log_p[$];
    int                 log_id[$];
    int                 log_cyc[$];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_log();
        log_p.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    // Scoreboard and protocol monitor for the main instance, called once per cycle at the falling edge.
    task automatic mon();
        exp_t                    e;
        logic [N_REQ-1:0]        xfer;
        logic signed [WIDTH-1:0] a_s, b_s;
        if (!rst_n) begin
            check("ready_in_reset", req_ready, 0);
            sb.delete();
            prev_stall = 1'b0;
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
            return;
        end
        xfer = req_valid & req_ready;
        check("ready_onehot", $countones(req_ready) <= 1, 1);
        if (prev_stall) begin
            check("stall_hold_valid", rsp_valid, 1);
            check("stall_hold_p", $signed(rsp_p), $signed(prev_p));
            check("stall_hold_id", rsp_id, prev_id);
        end
        if (rsp_valid && !rsp_ready) check("stall_no_grant", req_ready, 0);
        for (int i = 0; i < N_REQ; i++) begin
            if (xfer[i]) begin
                check("starve_wait", wait_cnt[i] <= N_REQ-1, 1);
                a_s  = req_a[i*WIDTH +: WIDTH];
                b_s  = req_b[i*WIDTH +: WIDTH];
                e.id = ID_W'(i);
                e.p  = (2*WIDTH)'(int'(a_s) * int'(b_s));
                sb.push_back(e);
                wait_cnt[i] = 0;
            end else if (!req_valid[i]) begin
                wait_cnt[i] = 0;
            end else if (xfer != '0) begin
                wait_cnt[i]++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            check("rsp_has_expect", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_p", $signed(rsp_p), $signed(e.p));
                check("rsp_id", rsp_id, e.id);
            end
            log_p.push_back($signed(rsp_p));
            log_id.push_back(int'(rsp_id));
            log_cyc.push_back(cyc);
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_p     = rsp_p;
        prev_id    = rsp_id;
    endtask

    task automatic at_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    mul_vec_t         mv[16];
    rr_vec_t          sw_tbl[4];
    logic [N_REQ-1:0] rr_exp[5];
    int               rr_ids[5];
    logic signed [WIDTH-1:0]   bp_a[3];
    logic signed [WIDTH-1:0]   bp_b[3];
    logic signed [2*WIDTH-1:0] bp_p[3];
    int n_iss;

    initial begin
        mv = '{
            '{2'b10, 2'b10, 4'b0100}, '{2'b10, 2'b11, 4'b0010}, '{2'b10, 2'b00, 4'b0000}, '{2'b10, 2'b01, 4'b1110},
            '{2'b11, 2'b10, 4'b0010}, '{2'b11, 2'b11, 4'b0001}, '{2'b11, 2'b00, 4'b0000}, '{2'b11, 2'b01, 4'b1111},
            '{2'b00, 2'b10, 4'b0000}, '{2'b00, 2'b11, 4'b0000}, '{2'b00, 2'b00, 4'b0000}, '{2'b00, 2'b01, 4'b0000},
            '{2'b01, 2'b10, 4'b1110}, '{2'b01, 2'b11, 4'b1111}, '{2'b01, 2'b00, 4'b0000}, '{2'b01, 2'b01, 4'b0001}
        };
        sw_tbl = '{'{4'b0100, 4'b0100}, '{4'b0010, 4'b0010}, '{4'b1001, 4'b1000}, '{4'b0001, 4'b0001}};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_ids = '{0, 1, 2, 3, 0};
        bp_a   = '{8'sd5, 8'sd7, 8'h80};
        bp_b   = '{-8'sd3, 8'sd7, 8'h80};
        bp_p   = '{-16'sd15, 16'sd49, 16'sd16384};

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        s_valid = '0; s_a = '0; s_b = '0; s_rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;

        // Reset values
        at_pos(); at_pos();
        at_neg();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_p", rsp_p, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_small_valid", s_rsp_valid, 0);
        at_pos();
        rst_n = 1'b1;

        // Exhaustive 2-bit products on the small instance
        for (int k = 0; k < 16; k++) begin
            s_valid = 2'b01;
            s_a = {2'b00, mv[k].a};
            s_b = {2'b00, mv[k].b};
            at_neg();
            check("ex_ready", s_ready, 2'b01);
            at_pos();
            s_valid = '0;
            at_neg();
            check("ex_not_yet", s_rsp_valid, 0);
            at_pos();
            at_neg();
            check("ex_valid", s_rsp_valid, 1);
            check("ex_p", $signed(s_rsp_p), mv[k].p);
            check("ex_id", s_rsp_id, 0);
            at_pos();
        end

        // Round-robin with every requester held valid from reset
        rst_n = 1'b0;
        req_valid = '1;
        req_a = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
        req_b = {-8'sd5, 8'sd9, -8'sd1, 8'sd127};
        at_neg();
        at_pos();
        rst_n = 1'b1;
        clear_log();
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 5) ? '1 : '0;
            at_neg();
            if (k < 5) check("rr_grant", req_ready, rr_exp[k]);
            at_pos();
        end
        check("rr_rsp_count", log_id.size(), 5);
        if (log_id.size() == 5) begin
            for (int k = 0; k < 5; k++) check("rr_rsp_id", log_id[k], rr_ids[k]);
            check("rr_back_to_back", log_cyc[4] - log_cyc[0], 4);
        end

        // Backpressure at the first response
        clear_log();
        n_iss = 0;
        for (int k = 0; k < 14; k++) begin
            req_valid = (n_iss < 3) ? 4'b0001 : 4'b0000;
            req_a[WIDTH-1:0] = bp_a[(n_iss < 3) ? n_iss : 0];
            req_b[WIDTH-1:0] = bp_b[(n_iss < 3) ? n_iss : 0];
            rsp_ready = !(k >= PIPE && k < PIPE + 4);
            at_neg();
            if (k >= PIPE && k < PIPE + 4) begin
                check("bp_valid", rsp_valid, 1);
                check("bp_p", $signed(rsp_p), -15);
                check("bp_no_ready", req_ready, 0);
            end
            if (req_ready[0]) n_iss++;
            at_pos();
        end
        rsp_ready = 1'b1;
        check("bp_rsp_count", log_p.size(), 3);
        if (log_p.size() == 3) begin
            for (int k = 0; k < 3; k++) check("bp_order", log_p[k], bp_p[k]);
        end

        // Sparse requests and pointer wrap (pointer moves 1 -> 3 -> 2 -> 0 -> 1)
        for (int k = 0; k < 4; k++) begin
            req_valid = sw_tbl[k].valid;
            at_neg();
            check("sw_grant", req_ready, sw_tbl[k].ready);
            at_pos();
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            at_neg(); at_pos();
        end

        // Reset with two operations in flight
        req_valid = '1;
        at_neg(); at_pos();
        at_neg(); at_pos();
        rst_n = 1'b0;
        at_neg();
        check("rm_ready_in_reset", req_ready, 0);
        at_pos();
        rst_n = 1'b1;
        at_neg();
        check("rm_no_stale_0", rsp_valid, 0);
        check("rm_grant_after", req_ready, 4'b0001);
        at_pos();
        req_valid = '0;
        at_neg();
        check("rm_no_stale_1", rsp_valid, 0);
        at_pos();
        at_neg();
        check("rm_new_valid", rsp_valid, 1);
        check("rm_new_id", rsp_id, 0);
        at_pos();

        // Random soak against the scoreboard
        for (int k = 0; k < 10000; k++) begin
            req_valid = ~(N_REQ'($urandom) & N_REQ'($urandom));
            req_a     = (N_REQ*WIDTH)'($urandom);
            req_b     = (N_REQ*WIDTH)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            at_neg();
            at_pos();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            at_neg();
            at_pos();
        end
        check("drain_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
